// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring integer divider (signed/unsigned)
// for the EX stage. One operation in flight; stalls the pipeline while busy
// and presents quotient/remainder with a one-cycle ready pulse.
// Optional build macro: DIV_ZERO_FAST_EN -- a zero divisor skips the
// iterations and goes straight to DONE with the divide-by-zero results.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             cancel,
  output logic             busy,
  output logic             stall_request,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH);

`ifdef DIV_ZERO_FAST_EN
  localparam bit FAST_DZ = 1'b1;
`else
  localparam bit FAST_DZ = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH:0]   prem;       // partial remainder, one extra bit for the trial subtract
  logic [WIDTH-1:0] shreg;      // dividend bits shift out of the top, quotient bits in at the bottom
  logic [WIDTH-1:0] dvs_r;      // divisor magnitude
  logic [CW-1:0]    cnt;
  logic             q_neg, r_neg;

  // Operand conditioning at accept time
  logic             accept, dvd_neg, dvs_neg, dvs_zero, fast_dz;
  logic [WIDTH-1:0] in_dvd_mag, in_dvs_mag;

  // One restoring step
  logic [WIDTH:0]   shifted, trial, prem_step;
  logic             q_bit;
  logic [WIDTH-1:0] q_step, q_fin, r_fin;

  assign accept     = (state != S_BUSY) && start && !cancel;
  assign dvd_neg    = signed_op && dividend[WIDTH-1];
  assign dvs_neg    = signed_op && divisor[WIDTH-1];
  assign dvs_zero   = (divisor == '0);
  assign fast_dz    = FAST_DZ && dvs_zero;
  assign in_dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
  assign in_dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;

  // prem stays below the divisor magnitude (or below 2^WIDTH for a zero
  // divisor), so its top bit is always clear and the shift loses nothing.
  assign shifted   = (prem << 1) | {{WIDTH{1'b0}}, shreg[WIDTH-1]};
  assign trial     = shifted - {1'b0, dvs_r};
  assign q_bit     = ~trial[WIDTH];
  assign prem_step = q_bit ? trial : shifted;
  assign q_step    = {shreg[WIDTH-2:0], q_bit};
  // A zero divisor clears q_neg at accept, so the all-ones quotient is kept
  // and negating the dividend magnitude restores the raw dividend.
  assign q_fin     = q_neg ? (~q_step + 1'b1) : q_step;
  assign r_fin     = r_neg ? (~prem_step[WIDTH-1:0] + 1'b1) : prem_step[WIDTH-1:0];

  assign busy  = (state == S_BUSY);
  assign ready = (state == S_DONE);
  // Gated by reset so a held start cannot stall the pipe during reset
  assign stall_request = reset && !cancel &&
                         ((state == S_BUSY) || ((state != S_BUSY) && start));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: cancel wins, DONE lasts one cycle unless a new op is issued
  always_comb begin
    state_nxt = state;
    if (cancel) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) state_nxt = fast_dz ? S_DONE : S_BUSY;
          else       state_nxt = S_IDLE;
        end
        S_BUSY:  if (cnt == '0) state_nxt = S_DONE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath: load on accept, iterate in BUSY, results only on the edge into DONE
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      prem      <= '0;
      shreg     <= '0;
      dvs_r     <= '0;
      cnt       <= '0;
      q_neg     <= 1'b0;
      r_neg     <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      prem  <= '0;
      shreg <= in_dvd_mag;
      dvs_r <= in_dvs_mag;
      cnt   <= CW'(WIDTH - 1);
      q_neg <= (dvd_neg ^ dvs_neg) && !dvs_zero;
      r_neg <= dvd_neg;
      if (fast_dz) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == S_BUSY && !cancel) begin
      prem  <= prem_step;
      shreg <= q_step;
      cnt   <= cnt - 1'b1;
      if (cnt == '0) begin
        quotient  <= q_fin;
        remainder <= r_fin;
      end
    end
  end

endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider for the EX stage of the MIPS pipeline, replacing the fixed 32-bit, unsigned-only divide path. It accepts one signed or unsigned divide at a time and iterates radix-2 restoring division for WIDTH cycles. It holds `stall_request` to the pipeline control block while the operation is in flight. Results are presented with a one-cycle `ready` pulse and held stable for HI/LO writeback until the next accepted operation.

## Interface
- WIDTH, 32, operand and result width in bits (≥4).
- clock  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request a divide; sampled only in IDLE or DONE.
- signed_op  in  1  1 = two's-complement divide, 0 = unsigned; sampled with start.
- dividend  in  WIDTH  numerator; sampled with start.
- divisor  in  WIDTH  denominator; sampled with start.
- cancel  in  1  flush; aborts any operation, highest priority.
- busy  out  1  high in BUSY state.
- stall_request  out  1  combinational: (IDLE or DONE) & start & ~cancel, or BUSY & ~cancel.
- ready  out  1  high exactly during DONE.
- quotient  out  WIDTH  registered quotient.
- remainder  out  WIDTH  registered remainder.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: start & ~cancel → capture operands and signed_op → BUSY. Load the iteration counter with WIDTH-1. Convert operands to magnitudes when signed_op=1, and record the quotient sign (dividend sign XOR divisor sign) and remainder sign (dividend sign).
- BUSY: each cycle performs one restoring step (shift the partial remainder left by 1 and bring in the next dividend MSB; trial subtract the divisor magnitude; if the result is non-negative, keep it and set quotient bit 1, else quotient bit 0), then decrements the counter. On the step where counter = 0, sign-correct the results, load quotient/remainder, and go → DONE.
- DONE: ready=1 for one cycle, then → IDLE. If start & ~cancel in DONE, accept the new operation and go → BUSY (back-to-back issue; ready is still high this cycle).
- start while BUSY: ignored.
- cancel: from any state → IDLE next edge. No ready pulse. quotient/remainder keep their previous values. cancel together with start: start is ignored.
- Partial remainder register is WIDTH+1 bits to hold the trial subtract; all other datapath registers are WIDTH bits.
- Sign rules: quotient negative iff signs differ; remainder takes the dividend's sign; negation is WIDTH-bit two's complement with wrap.
- Overflow: most-negative ÷ -1 → quotient = most-negative (wrapped), remainder 0. No flag is raised.
- Divisor = 0, in both signed and unsigned modes: quotient = all ones, remainder = raw dividend. No sign correction is applied.
- quotient and remainder change only on the edge entering DONE.

## Timing
- Reset values: state IDLE, busy 0, ready 0, quotient 0, remainder 0, counter 0. stall_request is 0 while reset is asserted.
- Reset released mid-operation: the block starts in IDLE; the prior operation is lost.
- Cycle numbering: start is high in cycle 0 and sampled at the end of cycle 0. BUSY covers cycles 1..WIDTH. DONE/ready is cycle WIDTH+1.
- Latency from start to ready: WIDTH+1 cycles. Throughput: one divide per WIDTH+1 cycles with back-to-back issue.
- stall_request is high in cycles 0..WIDTH and low in cycle WIDTH+1, so the EX stage advances while the result is valid.

## Configuration
- DIV_ZERO_FAST_EN defined: divisor = 0 at accept goes IDLE/DONE → DONE directly. ready is asserted in cycle 1 with the divide-by-zero results, and stall_request is high only in cycle 0.
- DIV_ZERO_FAST_EN undefined: divisor = 0 runs the full WIDTH iterations. Results are identical; latency is WIDTH+1.

## Test plan
- WIDTH=32, unsigned 100 ÷ 7, start in cycle 0 → ready only in cycle 33, quotient 14, remainder 2; busy high in cycles 1–32.
- Signed 0xFFFFFFF9 (-7) ÷ 2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 0x80000000 ÷ 0xFFFFFFFF → quotient 0x80000000, remainder 0.
- Signed 5 ÷ 0 → quotient 0xFFFFFFFF, remainder 5. ready in cycle 1 with DIV_ZERO_FAST_EN, cycle 33 without.
- After 100÷7 completes, start 50÷3 and assert cancel in cycle 10 → busy low in cycle 11, no ready, outputs still 14/2. A new start of 9÷4 → ready 33 cycles later with quotient 2, remainder 1.
- start asserted in DONE cycle 33 with 200÷9 → no IDLE cycle in between; ready in cycle 66 with quotient 22, remainder 2. Assert reset in cycle 40 → all outputs 0 immediately, state IDLE.
- WIDTH=8, unsigned 200 ÷ 3 → ready in cycle 9, quotient 66, remainder 2.
